// File: rtl/ps2_mouse_paddle_rx_if.sv
// Pin-side and paddle-side signals of the PS/2 mouse paddle receiver.
// The mouse (master) drives the PS/2 lines; the receiver (slave) drives the paddle outputs.
interface ps2_mouse_paddle_rx_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] paddle0_speed;
    logic       paddle0_dir;
    logic       new_data;
    logic       frame_err;

    modport master (
        output ps2_clk, ps2_data,
        input  paddle0_speed, paddle0_dir, new_data, frame_err
    );

    modport slave (
        input  ps2_clk, ps2_data,
        output paddle0_speed, paddle0_dir, new_data, frame_err
    );
endinterface

// File: rtl/ps2_mouse_paddle_rx.sv
// PS/2 mouse packet receiver: decodes Y motion into paddle0 speed/direction.
// Define PS2_PARITY_CHECK_EN to reject frames whose odd parity is wrong.
module ps2_mouse_paddle_rx #(
    parameter int SYNC_STAGES     = 2,
    parameter int TIMEOUT_CYCLES  = 25000,
    parameter int NEW_DATA_CYCLES = 2
) (
    input  logic                 clk_25MHz,
    input  logic                 reset,
    ps2_mouse_paddle_rx_if.slave bus,
    output logic [1:0]           fsm_state
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int NW = $clog2(NEW_DATA_CYCLES + 1);
`ifdef PS2_PARITY_CHECK_EN
    localparam bit PARITY_CHECK = 1'b1;
`else
    localparam bit PARITY_CHECK = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
    state_t state, state_next;

    logic [SYNC_STAGES-1:0] clk_sync, data_sync;
    logic          clk_prev, clk_s, data_s, fall;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          parity_bit;
    logic [1:0]    byte_idx;
    logic          flag_sign, flag_ovf;
    logic [TW-1:0] timer;
    logic          active, timeout, parity_ok, byte_ok, stop_bad;
    logic [8:0]    ysum, mag;
    logic [7:0]    speed_dec;
    logic [7:0]    speed;
    logic          dir, pend, frame_err;
    logic [NW-1:0] nd_cnt;

    assign clk_s     = clk_sync[SYNC_STAGES-1];
    assign data_s    = data_sync[SYNC_STAGES-1];
    assign fall      = clk_prev & ~clk_s;
    assign active    = (state != IDLE) || (byte_idx != 2'd0);
    assign timeout   = active && !fall && (timer == TW'(TIMEOUT_CYCLES - 1));
    assign parity_ok = !PARITY_CHECK || (^{shreg, parity_bit});
    assign fsm_state = state;

    // Idle PS/2 lines are high, so the synchronisers reset to 1 to avoid a phantom edge.
    always_ff @(posedge clk_25MHz or posedge reset) begin
        if (reset) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], bus.ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], bus.ps2_data};
            clk_prev  <= clk_s;
        end
    end

    always_ff @(posedge clk_25MHz or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        byte_ok    = 1'b0;
        stop_bad   = 1'b0;
        if (timeout) begin
            state_next = IDLE;
        end else if (fall) begin
            case (state)
                IDLE:    if (!data_s) state_next = DATA;
                DATA:    if (bit_cnt == 3'd7) state_next = PARITY;
                PARITY:  state_next = STOP;
                default: begin
                    state_next = IDLE;
                    if (data_s && parity_ok) byte_ok  = 1'b1;
                    else                     stop_bad = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk_25MHz or posedge reset) begin
        if (reset) timer <= '0;
        else if (fall || !active || timeout) timer <= '0;
        else timer <= timer + 1'b1;
    end

    // Y decode from the stored flags and the just-completed byte 2.
    assign ysum      = {flag_sign, shreg};
    assign mag       = flag_sign ? (~ysum + 9'd1) : ysum;
    assign speed_dec = (flag_ovf || mag[8]) ? 8'hFF : mag[7:0];

    always_ff @(posedge clk_25MHz or posedge reset) begin
        if (reset) begin
            bit_cnt    <= '0;
            shreg      <= '0;
            parity_bit <= 1'b0;
            byte_idx   <= '0;
            flag_sign  <= 1'b0;
            flag_ovf   <= 1'b0;
            speed      <= '0;
            dir        <= 1'b0;
            pend       <= 1'b0;
            nd_cnt     <= '0;
            frame_err  <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            pend      <= 1'b0;
            if (pend)               nd_cnt <= NW'(NEW_DATA_CYCLES);
            else if (nd_cnt != '0)  nd_cnt <= nd_cnt - 1'b1;

            if (fall) begin
                case (state)
                    IDLE:   bit_cnt <= '0;
                    DATA: begin
                        shreg   <= {data_s, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    PARITY: parity_bit <= data_s;
                    default: ;
                endcase
            end

            if (timeout || stop_bad) begin
                byte_idx  <= 2'd0;
                frame_err <= 1'b1;
            end else if (byte_ok) begin
                case (byte_idx)
                    2'd0: begin
                        // Bit 3 of the flags byte is always set; use it to realign.
                        if (shreg[3]) begin
                            flag_sign <= shreg[5];
                            flag_ovf  <= shreg[7];
                            byte_idx  <= 2'd1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    2'd1: byte_idx <= 2'd2;
                    default: begin
                        byte_idx <= 2'd0;
                        speed    <= speed_dec;
                        dir      <= ~flag_sign;
                        pend     <= 1'b1;
                    end
                endcase
            end
        end
    end

    // new_data rises one cycle after speed/dir settle and lasts NEW_DATA_CYCLES cycles.
    assign bus.paddle0_speed = speed;
    assign bus.paddle0_dir   = dir;
    assign bus.new_data      = (nd_cnt != '0);
    assign bus.frame_err     = frame_err;
endmodule

// File: tb/tb_ps2_mouse_paddle_rx.sv
// Bench for ps2_mouse_paddle_rx: directed packets, timeout, reset, then random packets
// with injected errors, checked against a packet-level decode model.
`timescale 1ns/1ps
module tb_ps2_mouse_paddle_rx;
    logic       clk_25MHz = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] fsm_state;

    always #20 clk_25MHz = ~clk_25MHz;

    ps2_mouse_paddle_rx_if bus();

    ps2_mouse_paddle_rx dut (
        .clk_25MHz (clk_25MHz),
        .reset     (reset),
        .bus       (bus.slave),
        .fsm_state (fsm_state)
    );

    int         checks = 0;
    int         errors = 0;
    logic [8:0] exp_q[$];
    int         cyc = 0;
    int         stop_cyc = 0;
    int         last_fall_cyc = 0;
    int         last_err_cyc = 0;
    int         half = 5;
    int         err_seen = 0;
    int         exp_err = 0;
    logic [7:0] last_speed = 8'd0;
    logic       last_dir = 1'b0;

    always @(posedge clk_25MHz) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Reference: Y is a 9-bit signed value; speed is its clamped magnitude.
    function automatic logic [8:0] model_decode(input logic [7:0] b0, input logic [7:0] b2);
        int y;
        int m;
        y = b0[5] ? int'(b2) - 256 : int'(b2);
        m = (y < 0) ? -y : y;
        if (b0[7] || m > 255) m = 255;
        return {(y >= 0), 8'(m)};
    endfunction

    // ---------------- monitor ----------------
    logic       nd_prev = 1'b0;
    logic       fe_prev = 1'b0;
    logic [7:0] speed_prev = 8'd0;
    int         nd_width = 0;
    logic [8:0] mon_exp;

    always @(negedge clk_25MHz) begin
        if (!reset) begin
            if (bus.new_data && !nd_prev) begin
                check("nd_latency", cyc - stop_cyc, 4);
                check("speed_setup", bus.paddle0_speed, speed_prev);
                if (exp_q.size() == 0) begin
                    check("nd_unexpected", exp_q.size(), 1);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("speed", bus.paddle0_speed, mon_exp[7:0]);
                    check("dir", bus.paddle0_dir, mon_exp[8]);
                end
                nd_width = 1;
            end else if (bus.new_data) begin
                nd_width++;
            end
            if (!bus.new_data && nd_prev) check("nd_width", nd_width, 2);
            if (bus.frame_err) begin
                err_seen++;
                last_err_cyc = cyc;
                check("fe_pulse", fe_prev, 0);
            end
        end
        nd_prev    = bus.new_data;
        fe_prev    = bus.frame_err;
        speed_prev = bus.paddle0_speed;
    end

    // ---------------- drivers ----------------
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int nbits);
        logic [10:0] f;
        f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk_25MHz);
            bus.ps2_data = f[i];
            repeat (half) @(negedge clk_25MHz);
            bus.ps2_clk = 1'b0;
            last_fall_cyc = cyc;
            if (i == 10) stop_cyc = cyc;
            repeat (half) @(negedge clk_25MHz);
            bus.ps2_clk = 1'b1;
        end
        @(negedge clk_25MHz);
        bus.ps2_data = 1'b1;
        repeat (half) @(negedge clk_25MHz);
    endtask

    task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                               input int bad_par_idx);
        logic [8:0] e;
        e = model_decode(b0, b2);
        exp_q.push_back(e);
        last_speed = e[7:0];
        last_dir   = e[8];
        send_frame(b0, bad_par_idx == 0, 1'b0, 11);
        send_frame(b1, bad_par_idx == 1, 1'b0, 11);
        send_frame(b2, bad_par_idx == 2, 1'b0, 11);
    endtask

    task automatic finish_trial(input string tag);
        repeat (12) @(negedge clk_25MHz);
        check({tag, "_nd_drain"}, exp_q.size(), 0);
        check({tag, "_err_count"}, err_seen, exp_err);
        check({tag, "_speed_hold"}, bus.paddle0_speed, last_speed);
        check({tag, "_dir_hold"}, bus.paddle0_dir, last_dir);
        exp_q.delete();
    endtask

    initial begin
        repeat (95000) @(posedge clk_25MHz);
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        int mode;
        int j;
        logic [7:0] b0, b1, b2;
        int d;

        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        repeat (3) @(negedge clk_25MHz);
        check("rst_speed", bus.paddle0_speed, 0);
        check("rst_dir", bus.paddle0_dir, 0);
        check("rst_new_data", bus.new_data, 0);
        check("rst_frame_err", bus.frame_err, 0);
        check("rst_fsm", fsm_state, 0);
        reset = 1'b0;
        repeat (3) @(negedge clk_25MHz);

        send_packet(8'h08, 8'h00, 8'h05, -1);
        finish_trial("t1");
        check("t1_speed", bus.paddle0_speed, 8'd5);
        check("t1_dir", bus.paddle0_dir, 1);

        send_packet(8'h28, 8'h00, 8'hF6, -1);
        finish_trial("t2a");
        check("t2a_speed", bus.paddle0_speed, 8'd10);
        check("t2a_dir", bus.paddle0_dir, 0);
        send_packet(8'h28, 8'h00, 8'h00, -1);
        finish_trial("t2b");
        check("t2b_speed", bus.paddle0_speed, 8'd255);

        send_packet(8'h88, 8'h00, 8'h10, -1);
        finish_trial("t3");
        check("t3_speed", bus.paddle0_speed, 8'd255);
        check("t3_dir", bus.paddle0_dir, 1);

        send_packet(8'h08, 8'h00, 8'h04, -1);
        finish_trial("t4pre");
`ifdef PS2_PARITY_CHECK_EN
        send_frame(8'h08, 1'b0, 1'b0, 11);
        send_frame(8'h00, 1'b0, 1'b0, 11);
        send_frame(8'h10, 1'b1, 1'b0, 11);
        exp_err++;
        finish_trial("t4");
        check("t4_speed", bus.paddle0_speed, 8'd4);
`else
        send_packet(8'h08, 8'h00, 8'h10, 2);
        finish_trial("t4");
        check("t4_speed", bus.paddle0_speed, 8'h10);
`endif

        send_frame(8'h00, 1'b0, 1'b0, 11);
        exp_err++;
        send_packet(8'h08, 8'h00, 8'h03, -1);
        finish_trial("t5");
        check("t5_speed", bus.paddle0_speed, 8'd3);

        send_frame(8'h08, 1'b0, 1'b0, 11);
        send_frame(8'h00, 1'b0, 1'b0, 5);
        bus.ps2_data = 1'b1;
        repeat (30000) @(negedge clk_25MHz);
        exp_err++;
        d = last_err_cyc - last_fall_cyc;
        check("t6_timeout_window", (d >= 25000 && d <= 25005), 1);
        finish_trial("t6a");
        send_packet(8'h08, 8'h00, 8'h07, -1);
        finish_trial("t6b");
        check("t6_speed", bus.paddle0_speed, 8'd7);

        send_frame(8'h28, 1'b0, 1'b0, 11);
        send_frame(8'h00, 1'b0, 1'b0, 11);
        send_frame(8'h40, 1'b0, 1'b0, 4);
        reset = 1'b1;
        #1;
        check("t7_rst_speed", bus.paddle0_speed, 0);
        check("t7_rst_dir", bus.paddle0_dir, 0);
        check("t7_rst_nd", bus.new_data, 0);
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        err_seen   = 0;
        exp_err    = 0;
        last_speed = 8'd0;
        last_dir   = 1'b0;
        repeat (3) @(negedge clk_25MHz);
        reset = 1'b0;
        repeat (3) @(negedge clk_25MHz);
        send_packet(8'h08, 8'h00, 8'h21, -1);
        finish_trial("t7");
        check("t7_speed", bus.paddle0_speed, 8'h21);

        for (int t = 0; t < 40; t++) begin
            half = $urandom_range(3, 6);
            mode = $urandom_range(0, 5);
            j    = $urandom_range(0, 2);
            b0   = 8'($urandom_range(0, 255)) | 8'h08;
            b1   = 8'($urandom_range(0, 255));
            b2   = 8'($urandom_range(0, 255));
            if (mode <= 2) begin
                send_packet(b0, b1, b2, -1);
            end else if (mode == 3) begin
                send_frame(b0 & 8'hF7, 1'b0, 1'b0, 11);
                exp_err++;
            end else if (mode == 4) begin
                if (j >= 1) send_frame(b0, 1'b0, 1'b0, 11);
                if (j >= 2) send_frame(b1, 1'b0, 1'b0, 11);
                send_frame(b2, 1'b0, 1'b1, 11);
                exp_err++;
            end else begin
`ifdef PS2_PARITY_CHECK_EN
                if (j >= 1) send_frame(b0, 1'b0, 1'b0, 11);
                if (j >= 2) send_frame(b1, 1'b0, 1'b0, 11);
                send_frame(b2, 1'b1, 1'b0, 11);
                exp_err++;
`else
                send_packet(b0, b1, b2, j);
`endif
            end
            finish_trial("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
